// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//   Issue/writeback sequencer sitting in front of the half-precision FPU.
//   Accepts one FP op from decode (valid/ready), holds opcode and operands
//   steady on the FPU inputs for LATENCY cycles, captures the FPU result and
//   overflow flag, then offers them to writeback (valid/ready). A sticky
//   overflow status bit accumulates overflow across ops until cleared.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_vld / o_rdy                decode handshake
//   i_opcode, i_a, i_b, i_rd     op select, operands, destination tag
//   o_fpu_vld                    one-cycle start pulse to the FPU
//   o_fpu_opcode, o_fpu_a/_b     held op and operands to the FPU
//   i_fpu_res, i_fpu_ovf         FPU result and overflow
//   o_wb_vld / i_wb_rdy          writeback handshake
//   o_wb_res, o_wb_rd, o_wb_ovf  captured result, tag and overflow
//   o_illegal                    one-cycle pulse: unsupported opcode consumed
//   o_sticky_ovf, i_clr_ovf      sticky overflow status and its clear
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int          LATENCY = 2,
  parameter int          DATA_W  = 16,
  parameter logic [3:0]  OP_ADD  = 4'b1110,
  parameter logic [3:0]  OP_MUL  = 4'b1111
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  output logic              o_rdy,
  input  logic [3:0]        i_opcode,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_rd,
  output logic              o_fpu_vld,
  output logic [3:0]        o_fpu_opcode,
  output logic [DATA_W-1:0] o_fpu_a,
  output logic [DATA_W-1:0] o_fpu_b,
  input  logic [DATA_W-1:0] i_fpu_res,
  input  logic              i_fpu_ovf,
  output logic              o_wb_vld,
  input  logic              i_wb_rdy,
  output logic [DATA_W-1:0] o_wb_res,
  output logic [3:0]        o_wb_rd,
  output logic              o_wb_ovf,
  output logic              o_illegal,
  output logic              o_sticky_ovf,
  input  logic              i_clr_ovf
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_legal;

  assign op_legal = (i_opcode == OP_ADD) || (i_opcode == OP_MUL);

  // Ready is the only combinational output; it drops immediately under reset
  // so decode never sees a handshake that the reset edge would discard.
  assign o_rdy = (state == IDLE) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      o_fpu_vld    <= 1'b0;
      o_fpu_opcode <= '0;
      o_fpu_a      <= '0;
      o_fpu_b      <= '0;
      o_wb_vld     <= 1'b0;
      o_wb_res     <= '0;
      o_wb_rd      <= '0;
      o_wb_ovf     <= 1'b0;
      o_illegal    <= 1'b0;
      o_sticky_ovf <= 1'b0;
    end else begin
      o_fpu_vld <= 1'b0;
      o_illegal <= 1'b0;

      // Clear first; a capture with overflow later in this block overrides it,
      // so a coincident set and clear leaves the flag set.
      if (i_clr_ovf) o_sticky_ovf <= 1'b0;

      case (state)
        IDLE: begin
          if (i_vld) begin
            if (op_legal) begin
              o_fpu_opcode <= i_opcode;
              o_fpu_a      <= i_a;
              o_fpu_b      <= i_b;
              o_wb_rd      <= i_rd;
              o_fpu_vld    <= 1'b1;
              cnt          <= CNT_W'(LATENCY - 1);
              state        <= EXEC;
            end else begin
              // Unsupported op is consumed and flagged; nothing reaches the FPU.
              o_illegal <= 1'b1;
            end
          end
        end

        EXEC: begin
          if (cnt == '0) begin
            o_wb_res <= i_fpu_res;
            o_wb_ovf <= i_fpu_ovf;
            o_wb_vld <= 1'b1;
            if (i_fpu_ovf) o_sticky_ovf <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          if (i_wb_rdy) begin
            o_wb_vld <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with LATENCY=2. The bench plays the FPU:
// it drives a junk result (16'hDEAD, overflow 1) except in the single cycle
// where the controller should capture, so a capture on the wrong edge shows
// up as a wrong o_wb_res / o_wb_ovf / o_sticky_ovf.
module tb_fpu_issue_ctrl;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] JUNK = 16'hDEAD;

  logic              i_clk;
  logic              i_rst;
  logic              i_vld;
  logic              o_rdy;
  logic [3:0]        i_opcode;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic [3:0]        i_rd;
  logic              o_fpu_vld;
  logic [3:0]        o_fpu_opcode;
  logic [DATA_W-1:0] o_fpu_a;
  logic [DATA_W-1:0] o_fpu_b;
  logic [DATA_W-1:0] i_fpu_res;
  logic              i_fpu_ovf;
  logic              o_wb_vld;
  logic              i_wb_rdy;
  logic [DATA_W-1:0] o_wb_res;
  logic [3:0]        o_wb_rd;
  logic              o_wb_ovf;
  logic              o_illegal;
  logic              o_sticky_ovf;
  logic              i_clr_ovf;

  int checks;
  int failures;

  fpu_issue_ctrl #(
    .LATENCY(2),
    .DATA_W (DATA_W),
    .OP_ADD (4'b1110),
    .OP_MUL (4'b1111)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_vld       (i_vld),
    .o_rdy       (o_rdy),
    .i_opcode    (i_opcode),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_rd        (i_rd),
    .o_fpu_vld   (o_fpu_vld),
    .o_fpu_opcode(o_fpu_opcode),
    .o_fpu_a     (o_fpu_a),
    .o_fpu_b     (o_fpu_b),
    .i_fpu_res   (i_fpu_res),
    .i_fpu_ovf   (i_fpu_ovf),
    .o_wb_vld    (o_wb_vld),
    .i_wb_rdy    (i_wb_rdy),
    .o_wb_res    (o_wb_res),
    .o_wb_rd     (o_wb_rd),
    .o_wb_ovf    (o_wb_ovf),
    .o_illegal   (o_illegal),
    .o_sticky_ovf(o_sticky_ovf),
    .i_clr_ovf   (i_clr_ovf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one legal op and run it to the DONE cycle. Returns #1 after the edge
  // that enters DONE, with writeback outputs checked.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] rd, input logic [15:0] res, input logic ovf,
                       input logic clr_at_cap);
    i_vld = 1'b1; i_opcode = op; i_a = a; i_b = b; i_rd = rd;
    i_fpu_res = JUNK; i_fpu_ovf = 1'b1;
    chk("issue_rdy", {31'd0, o_rdy}, 32'd1);
    tick();                                   // accept edge T; now cycle T+1
    i_vld = 1'b0; i_opcode = 4'd0; i_a = '0; i_b = '0; i_rd = '0;
    chk("exec1_fpu_vld", {31'd0, o_fpu_vld}, 32'd1);
    chk("exec1_fpu_a", {16'd0, o_fpu_a}, {16'd0, a});
    chk("exec1_fpu_b", {16'd0, o_fpu_b}, {16'd0, b});
    chk("exec1_fpu_op", {28'd0, o_fpu_opcode}, {28'd0, op});
    chk("exec1_rdy", {31'd0, o_rdy}, 32'd0);
    chk("exec1_wb_vld", {31'd0, o_wb_vld}, 32'd0);
    tick();                                   // cycle T+2: capture at its end
    chk("exec2_fpu_vld", {31'd0, o_fpu_vld}, 32'd0);
    chk("exec2_fpu_a", {16'd0, o_fpu_a}, {16'd0, a});
    chk("exec2_wb_vld", {31'd0, o_wb_vld}, 32'd0);
    i_fpu_res = res; i_fpu_ovf = ovf; i_clr_ovf = clr_at_cap;
    tick();                                   // cycle T+3: DONE
    i_fpu_res = JUNK; i_fpu_ovf = 1'b1; i_clr_ovf = 1'b0;
    chk("done_wb_vld", {31'd0, o_wb_vld}, 32'd1);
    chk("done_wb_res", {16'd0, o_wb_res}, {16'd0, res});
    chk("done_wb_rd", {28'd0, o_wb_rd}, {28'd0, rd});
    chk("done_wb_ovf", {31'd0, o_wb_ovf}, {31'd0, ovf});
    chk("done_rdy", {31'd0, o_rdy}, 32'd0);
  endtask

  task automatic handshake();
    i_wb_rdy = 1'b1;
    tick();
    i_wb_rdy = 1'b0;
    chk("hs_wb_vld", {31'd0, o_wb_vld}, 32'd0);
    chk("hs_rdy", {31'd0, o_rdy}, 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_rst = 1'b1; i_vld = 1'b0; i_opcode = '0; i_a = '0; i_b = '0; i_rd = '0;
    i_fpu_res = JUNK; i_fpu_ovf = 1'b0; i_wb_rdy = 1'b0; i_clr_ovf = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_rdy", {31'd0, o_rdy}, 32'd0);
    chk("rst_fpu_vld", {31'd0, o_fpu_vld}, 32'd0);
    chk("rst_wb_vld", {31'd0, o_wb_vld}, 32'd0);
    chk("rst_sticky", {31'd0, o_sticky_ovf}, 32'd0);
    chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'd0, o_rdy}, 32'd1);

    // 1. Add 1.0 + 1.0 = 2.0
    issue(4'b1110, 16'h3C00, 16'h3C00, 4'd3, 16'h4000, 1'b0, 1'b0);
    chk("t1_sticky", {31'd0, o_sticky_ovf}, 32'd0);
    handshake();

    // 2. Mul 2.0 * 3.0 = 6.0; ready one cycle after the handshake
    issue(4'b1111, 16'h4000, 16'h4200, 4'd9, 16'h4600, 1'b0, 1'b0);
    handshake();

    // 3. Overflow and the sticky flag
    issue(4'b1111, 16'h7BFF, 16'h7BFF, 4'd1, 16'h7C00, 1'b1, 1'b0);
    chk("t3_sticky_set", {31'd0, o_sticky_ovf}, 32'd1);
    handshake();
    issue(4'b1110, 16'h3C00, 16'h3C00, 4'd2, 16'h4000, 1'b0, 1'b0);
    chk("t3_sticky_kept", {31'd0, o_sticky_ovf}, 32'd1);
    handshake();
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("t3_sticky_clr", {31'd0, o_sticky_ovf}, 32'd0);
    issue(4'b1111, 16'h7BFF, 16'h7BFF, 4'd4, 16'h7C00, 1'b1, 1'b1);
    chk("t3_set_wins", {31'd0, o_sticky_ovf}, 32'd1);
    handshake();
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("t3_sticky_clr2", {31'd0, o_sticky_ovf}, 32'd0);

    // 4. Backpressure with a new op waiting
    issue(4'b1110, 16'h3C00, 16'h3C00, 4'd5, 16'h4000, 1'b0, 1'b0);
    i_vld = 1'b1; i_opcode = 4'b1111; i_a = 16'h4000; i_b = 16'h4200; i_rd = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_wb_vld", {31'd0, o_wb_vld}, 32'd1);
      chk("bp_wb_res", {16'd0, o_wb_res}, 32'h4000);
      chk("bp_wb_rd", {28'd0, o_wb_rd}, 32'd5);
      chk("bp_rdy", {31'd0, o_rdy}, 32'd0);
      chk("bp_fpu_vld", {31'd0, o_fpu_vld}, 32'd0);
      chk("bp_fpu_a", {16'd0, o_fpu_a}, 32'h3C00);
      chk("bp_sticky", {31'd0, o_sticky_ovf}, 32'd0);
    end
    handshake();
    issue(4'b1111, 16'h4000, 16'h4200, 4'd7, 16'h4600, 1'b0, 1'b0);
    handshake();

    // 5. Illegal opcode
    i_vld = 1'b1; i_opcode = 4'b0011; i_a = 16'h1111; i_b = 16'h2222; i_rd = 4'd6;
    tick();
    i_vld = 1'b0; i_opcode = '0;
    chk("ill_pulse", {31'd0, o_illegal}, 32'd1);
    chk("ill_fpu_vld", {31'd0, o_fpu_vld}, 32'd0);
    chk("ill_rdy", {31'd0, o_rdy}, 32'd1);
    chk("ill_wb_vld", {31'd0, o_wb_vld}, 32'd0);
    tick();
    chk("ill_pulse_end", {31'd0, o_illegal}, 32'd0);
    chk("ill_wb_vld2", {31'd0, o_wb_vld}, 32'd0);
    chk("ill_rdy2", {31'd0, o_rdy}, 32'd1);
    tick();
    chk("ill_wb_vld3", {31'd0, o_wb_vld}, 32'd0);

    // 6. Reset mid-op, with sticky set beforehand
    issue(4'b1111, 16'h7BFF, 16'h7BFF, 4'd8, 16'h7C00, 1'b1, 1'b0);
    handshake();
    chk("t6_sticky_pre", {31'd0, o_sticky_ovf}, 32'd1);
    i_vld = 1'b1; i_opcode = 4'b1110; i_a = 16'h3C00; i_b = 16'h4000; i_rd = 4'd11;
    tick();                                   // first EXEC cycle
    i_vld = 1'b0;
    chk("t6_fpu_vld", {31'd0, o_fpu_vld}, 32'd1);
    tick();                                   // second EXEC cycle
    i_rst = 1'b1;
    i_fpu_res = 16'h4200; i_fpu_ovf = 1'b1;
    #1;
    chk("t6_rdy_in_rst", {31'd0, o_rdy}, 32'd0);
    tick();
    chk("t6_rdy", {31'd0, o_rdy}, 32'd0);
    chk("t6_fpu_vld0", {31'd0, o_fpu_vld}, 32'd0);
    chk("t6_fpu_op", {28'd0, o_fpu_opcode}, 32'd0);
    chk("t6_fpu_a", {16'd0, o_fpu_a}, 32'd0);
    chk("t6_fpu_b", {16'd0, o_fpu_b}, 32'd0);
    chk("t6_wb_vld", {31'd0, o_wb_vld}, 32'd0);
    chk("t6_wb_res", {16'd0, o_wb_res}, 32'd0);
    chk("t6_wb_rd", {28'd0, o_wb_rd}, 32'd0);
    chk("t6_wb_ovf", {31'd0, o_wb_ovf}, 32'd0);
    chk("t6_illegal", {31'd0, o_illegal}, 32'd0);
    chk("t6_sticky", {31'd0, o_sticky_ovf}, 32'd0);
    i_rst = 1'b0;
    i_fpu_res = JUNK;
    #1;
    chk("t6_rdy_after", {31'd0, o_rdy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_wb", {31'd0, o_wb_vld}, 32'd0);
      chk("t6_idle_rdy", {31'd0, o_rdy}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
